// File: rtl/apb_master_if.sv
// APB bus bundle between the requester-side bridge and the 8-bit slave memory.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by holding PREADY low in ACCESS.
//   PSEL, PENABLE, READ_WRITE, paddr, apb_write_data : master -> slave
//   prdata, PREADY                                   : slave  -> master
interface apb_master_if;
    logic       PSEL;
    logic       PENABLE;
    logic       READ_WRITE;
    logic [7:0] paddr;
    logic [7:0] apb_write_data;
    logic [7:0] prdata;
    logic       PREADY;

    modport master (
        output PSEL,
        output PENABLE,
        output READ_WRITE,
        output paddr,
        output apb_write_data,
        input  prdata,
        input  PREADY
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  READ_WRITE,
        input  paddr,
        input  apb_write_data,
        output prdata,
        output PREADY
    );
endinterface

// File: rtl/apb_master.sv
// Requester-side APB bridge: one-cycle request strobe -> APB SETUP/ACCESS sequence.
// Latency: request edge to xfer_done is 2 cycles with a zero-wait slave, 3 with the registered-PREADY slave.
// Backpressure: ACCESS holds while PREADY=0; new requests are sampled only in IDLE or on a completing ACCESS edge.
//
// Ports:
//   PCLK, PRESETn          clock; asynchronous reset, active high (1 = reset)
//   transfer               request strobe
//   rw_in, addr_in, wdata_in  request direction (1 = read), address, write data
//   apb (master modport)   PSEL, PENABLE, READ_WRITE, paddr, apb_write_data out; prdata, PREADY in
//   rdata_out              last successful read data, held until the next successful read
//   xfer_done              one-cycle pulse on transfer termination (success or timeout)
//   busy                   high whenever the FSM is not IDLE
//   err                    one-cycle pulse with xfer_done on timeout abort
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to build the ACCESS watchdog
// (aborts after TIMEOUT wait cycles). Without it err is tied low and ACCESS
// waits indefinitely.
module apb_master #(
    parameter int TIMEOUT = 16    // ACCESS wait cycles before abort, 1..255
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  logic         transfer,
    input  logic         rw_in,
    input  logic [7:0]   addr_in,
    input  logic [7:0]   wdata_in,
    apb_master_if.master apb,
    output logic [7:0]   rdata_out,
    output logic         xfer_done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       capture;     // latch request fields this edge
    logic       complete;    // ACCESS finished with PREADY
    logic       abort;       // ACCESS terminated by the watchdog

    logic       busy_q;
    logic       penable_q;
    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       done_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       err_q;
`endif

    // ---------------- next-state / control ----------------
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                    capture = 1'b1;
                end
            end
            // PREADY is deliberately ignored here: the slave's registered
            // PREADY can still be high from the previous transfer.
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    complete = 1'b1;
                    if (transfer) begin
                        state_d = SETUP;   // back-to-back, PSEL stays high
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // cnt_q counts completed wait cycles; the edge ending wait
                // cycle number TIMEOUT aborts. PREADY above takes priority.
                else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef APB_MASTER_TIMEOUT_EN
        if (capture) begin
            cnt_d = 8'd0;
        end
`endif
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- registered outputs ----------------
    // Phase outputs are decoded from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            busy_q    <= 1'b0;
            penable_q <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            busy_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            if (capture) begin
                rw_q    <= rw_in;
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
            end
            if (complete && rw_q) begin
                rdata_q <= apb.prdata;
            end
            done_q <= complete | abort;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign apb.PSEL           = busy_q;
    assign apb.PENABLE        = penable_q;
    assign apb.READ_WRITE     = rw_q;
    assign apb.paddr          = addr_q;
    assign apb.apb_write_data = wdata_q;
    assign rdata_out          = rdata_q;
    assign xfer_done          = done_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: 8-bit APB memory slave with registered PREADY, an
// override on PREADY for stall scenarios, and a scoreboard of expected
// completions checked by an independent monitor on xfer_done.
module tb_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       transfer;
    logic       rw_in;
    logic [7:0] addr_in;
    logic [7:0] wdata_in;
    logic [7:0] rdata_out;
    logic       xfer_done;
    logic       busy;
    logic       err;

    apb_master_if bus();

    apb_master #(.TIMEOUT(4)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .transfer  (transfer),
        .rw_in     (rw_in),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .apb       (bus),
        .rdata_out (rdata_out),
        .xfer_done (xfer_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- slave memory ----------------
    logic [7:0] mem [256];
    logic       slv_pready;
    logic [7:0] slv_prdata;
    logic       ovr_en  = 1'b0;
    logic       ovr_val = 1'b0;

    always @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            slv_pready <= 1'b0;
            slv_prdata <= 8'h00;
        end else begin
            slv_pready <= bus.PSEL & bus.PENABLE;
            if (bus.PSEL && bus.PENABLE) begin
                if (bus.READ_WRITE) slv_prdata <= mem[bus.paddr];
                else                mem[bus.paddr] <= bus.apb_write_data;
            end
        end
    end

    assign bus.PREADY = ovr_en ? ovr_val : slv_pready;
    assign bus.prdata = slv_prdata;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       err;
        logic [7:0] rd;
        int         done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge PCLK) begin
        if (xfer_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_err", err, mon_e.err);
                chk("done_rdata", rdata_out, mon_e.rd);
                chk("done_cycle", cyc, mon_e.done);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Presents one request for a single cycle; returns at the SETUP negedge.
    task automatic single(input logic rw, input logic [7:0] a, input logic [7:0] d,
                          input bit push, input logic e_err, input logic [7:0] e_rd,
                          input int lat);
        @(negedge PCLK);
        transfer = 1'b1;
        rw_in    = rw;
        addr_in  = a;
        wdata_in = d;
        if (push) sb.push_back('{e_err, e_rd, cyc + lat});
        @(negedge PCLK);
        transfer = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge PCLK);
            if (!busy) ok = 1'b1;
        end
        chk(name, ok, 1);
    endtask

    int psel_drops = 0;
    int en_low     = 0;

    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge PCLK);
            if (!bus.PSEL)    psel_drops++;
            if (!bus.PENABLE) en_low++;
            if (bus.PENABLE && bus.PREADY) ok = 1'b1;
        end
        chk("b2b_handshake", ok, 1);
    endtask

    task automatic run_b2b();
        logic       b_rw [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] b_a  [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
        logic [7:0] b_d  [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
        logic [7:0] b_rd [4] = '{8'hA5, 8'hA5, 8'h11, 8'h22};
        int  c0;
        bit  ok;
        @(negedge PCLK);
        c0 = cyc;
        transfer = 1'b1;
        rw_in = b_rw[0]; addr_in = b_a[0]; wdata_in = b_d[0];
        sb.push_back('{1'b0, b_rd[0], c0 + 4});
        for (int i = 1; i < 4; i++) begin
            wait_hs(ok);
            rw_in = b_rw[i]; addr_in = b_a[i]; wdata_in = b_d[i];
            sb.push_back('{1'b0, b_rd[i], c0 + 4 + 3 * i});
        end
        wait_hs(ok);
        transfer = 1'b0;
        wait_idle("b2b_idle", 10);
        chk("b2b_psel_drops", psel_drops, 0);
        chk("b2b_penable_low_cycles", en_low, 4);
    endtask

    // Asserts reset mid-ACCESS and checks the asynchronous return to reset values.
    task automatic reset_mid_access();
        chk("rst_pre_penable", bus.PENABLE, 1);
        PRESETn = 1'b1;
        #1;
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_read_write", bus.READ_WRITE, 0);
        chk("rst_paddr", bus.paddr, 8'h00);
        chk("rst_wdata", bus.apb_write_data, 8'h00);
        chk("rst_rdata_out", rdata_out, 8'h00);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b0;
        ovr_en  = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("post_rst_busy", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        PRESETn  = 1'b1;
        transfer = 1'b0;
        rw_in    = 1'b0;
        addr_in  = 8'h00;
        wdata_in = 8'h00;
        repeat (2) @(negedge PCLK);
        chk("init_psel", bus.PSEL, 0);
        chk("init_penable", bus.PENABLE, 0);
        chk("init_busy", busy, 0);
        chk("init_xfer_done", xfer_done, 0);
        chk("init_rdata_out", rdata_out, 8'h00);
        PRESETn = 1'b0;

        // write 0x3C <- 0xA5 with phase checks, then read it back
        single(1'b0, 8'h3C, 8'hA5, 1'b1, 1'b0, 8'h00, 4);
        chk("wr_setup_psel", bus.PSEL, 1);
        chk("wr_setup_penable", bus.PENABLE, 0);
        @(negedge PCLK);
        chk("wr_access_penable", bus.PENABLE, 1);
        chk("wr_access_paddr", bus.paddr, 8'h3C);
        chk("wr_access_wdata", bus.apb_write_data, 8'hA5);
        chk("wr_access_dir", bus.READ_WRITE, 0);
        wait_idle("wr_idle", 10);
        single(1'b1, 8'h3C, 8'h00, 1'b1, 1'b0, 8'hA5, 4);
        wait_idle("rd_idle", 10);
        chk("idle_keeps_paddr", bus.paddr, 8'h3C);

        // back-to-back writes and reads with transfer held high
        run_b2b();

        // stale PREADY high through SETUP, low in first ACCESS cycle
        ovr_en  = 1'b1;
        ovr_val = 1'b1;
        single(1'b0, 8'h50, 8'h5A, 1'b1, 1'b0, 8'h22, 4);
        @(negedge PCLK);
        chk("stale_no_done_in_setup", xfer_done, 0);
        chk("stale_access_penable", bus.PENABLE, 1);
        ovr_val = 1'b0;
        @(negedge PCLK);
        chk("stale_waiting_no_done", xfer_done, 0);
        chk("stale_waiting_penable", bus.PENABLE, 1);
        ovr_en = 1'b0;
        wait_idle("stale_idle", 10);

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY stuck low: abort after 4 ACCESS cycles, rdata_out held
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        single(1'b1, 8'h10, 8'h00, 1'b1, 1'b1, 8'h22, 6);
        wait_idle("timeout_idle", 20);
        chk("timeout_psel", bus.PSEL, 0);
        chk("timeout_rdata_held", rdata_out, 8'h22);

        // PREADY rises on the 4th ACCESS cycle: normal completion wins
        single(1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 8'h11, 6);
        repeat (4) @(negedge PCLK);
        ovr_val = 1'b1;
        wait_idle("edge_idle", 10);
        ovr_val = 1'b0;

        // reset mid-ACCESS; no completion may be reported
        single(1'b0, 8'h70, 8'h77, 1'b0, 1'b0, 8'h00, 0);
        @(negedge PCLK);
        reset_mid_access();
`else
        // without the watchdog a stalled ACCESS never terminates
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        single(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        repeat (30) @(negedge PCLK);
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_err", err, 0);
        reset_mid_access();
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master.md
# apb_master

Requester-side APB bridge that converts a simple one-cycle transfer request into an APB SETUP/ACCESS sequence and drives the 8-bit APB slave memory directly. Sits upstream of the slave. Its APB-side ports connect by name: PSEL, PENABLE, READ_WRITE, paddr, apb_write_data, prdata, PREADY. Returns read data and a completion pulse to the requesting logic, with an optional access-timeout watchdog.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort; legal 1..255 (only used with timeout feature)
- PCLK  input  1  sole clock, all state on rising edge
- PRESETn  input  1  reset: asynchronous, active-high (name kept for codebase consistency; 1 = reset)
- transfer  input  1  request strobe; sampled only when a new transfer may start
- rw_in  input  1  request direction: 1 = read, 0 = write
- addr_in  input  8  request address
- wdata_in  input  8  request write data
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable (ACCESS phase)
- READ_WRITE  output  1  APB direction, 1 = read, 0 = write
- paddr  output  8  APB address
- apb_write_data  output  8  APB write data
- prdata  input  8  APB read data from slave
- PREADY  input  1  APB ready from slave (registered in slave)
- rdata_out  output  8  last successful read data, held until next successful read
- xfer_done  output  1  one-cycle pulse on transfer termination (success or timeout)
- busy  output  1  high whenever state != IDLE
- err  output  1  one-cycle pulse coincident with xfer_done on timeout abort; constant 0 without feature

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: PSEL=0, PENABLE=0. transfer=1 → SETUP. rw_in/addr_in/wdata_in captured into READ_WRITE/paddr/apb_write_data at the same edge.
- SETUP: PSEL=1, PENABLE=0. Unconditional → ACCESS next edge. PREADY ignored.
- ACCESS: PSEL=1, PENABLE=1; paddr/READ_WRITE/apb_write_data stable.
  - PREADY=1 → complete. Pulse xfer_done. If READ_WRITE=1, load rdata_out from prdata.
    - transfer=1 at this edge → SETUP with new fields captured (back-to-back, PSEL stays 1).
    - transfer=0 → IDLE.
  - PREADY=0 → stay (wait state).
- PREADY is only evaluated in ACCESS. A stale PREADY=1 carried into SETUP by the slave's registered output is ignored.
- paddr/READ_WRITE/apb_write_data keep their last values in IDLE; they are not cleared.
- Reset (any state, any cycle): immediate return to IDLE. No xfer_done is generated for an interrupted transfer.
- Reset values: PSEL 0, PENABLE 0, READ_WRITE 0, paddr 0x00, apb_write_data 0x00, rdata_out 0x00, xfer_done 0, busy 0, err 0, timeout counter 0.

## Timing
- Edge E0: transfer seen in IDLE → E0+: SETUP.
- E1 → ACCESS, PENABLE=1.
- E2: slave samples PSEL/PENABLE and raises PREADY.
- E3: master sees PREADY=1 → xfer_done=1 and rdata_out valid after E3.
- Request-to-done latency with this slave: 3 cycles. Minimum with zero-wait slave: 2 cycles.
- Back-to-back throughput: one transfer per 3 cycles with this slave (SETUP, ACCESS, ACCESS-wait).
- The slave re-executes the write during the extra ACCESS cycle. The same address and data are rewritten, which is harmless.
- xfer_done and err are high for exactly one cycle, following the completion edge.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - 8-bit counter clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT with PREADY still 0, the transfer aborts: → IDLE regardless of transfer, xfer_done=1, err=1, rdata_out unchanged.
  - PREADY=1 on the same edge wins (normal completion, err=0).
- Not defined: no counter is built, err is tied to 0, and ACCESS waits indefinitely.

## Test plan
- Reset: assert PRESETn mid-ACCESS → all outputs return to reset values within the same cycle (asynchronous), and no xfer_done is generated.
- Write then read: write addr 0x3C data 0xA5, then read 0x3C → write xfer_done 3 cycles after request, apb_write_data=0xA5 during ACCESS, rdata_out=0xA5 after read done, err=0.
- Back-to-back: transfer held high for writes 0x01→0x11 and 0x02→0x22, then reads 0x01 and 0x02 → PSEL never drops between transfers, PENABLE=0 for one cycle between them, rdata_out is 0x11 then 0x22.
- Stale PREADY: PREADY forced 1 during SETUP, 0 in first ACCESS cycle → master does not complete in SETUP and waits in ACCESS.
- Timeout (macro on, TIMEOUT=4): PREADY tied 0, read 0x10 → after 4 ACCESS cycles xfer_done=1 and err=1, rdata_out keeps previous value, state IDLE. With macro off → busy stays 1 indefinitely.
- PREADY on the timeout edge (TIMEOUT=4): PREADY rises on the 4th ACCESS cycle → normal completion, err=0.
